// File: rtl/chaos_pixel_diffuser.sv
// Quantizes FP32 chaotic samples into key bytes and XOR-diffuses them into a pixel stream, one image per start.
// Define CIPHER_CHAIN_EN to chain each ciphertext into the next pixel (seeded with IV); otherwise pure stream XOR.
module chaos_pixel_diffuser #(
  parameter int PRECISION = 32,
  parameter int PIXEL_W   = 8,
  parameter int SHIFT     = 24,
  parameter int NUM_PIX   = 16,
  parameter logic [PIXEL_W-1:0] IV = 8'h5A
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 chaos_valid,
  output logic                 chaos_ready,
  input  logic [PRECISION-1:0] chaos_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIXEL_W-1:0]   pix_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIXEL_W-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 nan_seen
);

  localparam int CNT_W  = $clog2(NUM_PIX + 1);
  localparam int MANT_W = 24;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_next;
  logic                 key_full;
  logic [PIXEL_W-1:0]   key;
  logic [PIXEL_W-1:0]   key_q;
  logic [CNT_W-1:0]     count;
  logic [7:0]           exp_f;
  logic [MANT_W-1:0]    mant;
  logic                 unused_sign;
  logic                 fire;
  logic                 chaos_hs;
  logic                 count_is_last;
  logic [PIXEL_W-1:0]   cipher;
  int                   shamt;

  assign exp_f         = chaos_in[30:23];
  assign mant          = {1'b1, chaos_in[22:0]};
  assign unused_sign   = chaos_in[PRECISION-1];
  assign count_is_last = (count == CNT_W'(NUM_PIX - 1));

  assign chaos_ready = (state == RUN) && !key_full;
  assign chaos_hs    = chaos_valid && chaos_ready;
  assign fire        = (state == RUN) && key_full && pix_valid && (!out_valid || out_ready);
  assign pix_ready   = fire;
  assign busy        = (state != IDLE);

  // key = floor(|x| * 2^SHIFT) mod 2^PIXEL_W; only the low key bits of the shifted mantissa matter
  always_comb begin
    key_q = '0;
    shamt = int'(exp_f) - 150 + SHIFT;
    if (exp_f != 8'h00 && exp_f != 8'hFF) begin
      if (shamt >= 0) begin
        if (shamt < PIXEL_W) key_q = PIXEL_W'(mant << shamt);
      end else if (shamt > -MANT_W) begin
        key_q = PIXEL_W'(mant >> (-shamt));
      end
    end
  end

`ifdef CIPHER_CHAIN_EN
  logic [PIXEL_W-1:0] chain;
  assign cipher = pix_in ^ key ^ chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  chain <= IV;
    else if (state == IDLE && start) chain <= IV;
    else if (fire)                 chain <= cipher;
  end
`else
  localparam logic [PIXEL_W-1:0] UNUSED_IV = IV;
  assign cipher = pix_in ^ key;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (fire && count_is_last) state_next = DONE;
      DONE:    if (out_valid && out_ready && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Key capture and key consumption are mutually exclusive through key_full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_full  <= 1'b0;
      key       <= '0;
      count     <= '0;
      nan_seen  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        count    <= '0;
        nan_seen <= 1'b0;
      end
      if (chaos_hs) begin
        key      <= key_q;
        key_full <= 1'b1;
        if (exp_f == 8'hFF) nan_seen <= 1'b1;
      end
      if (fire) begin
        out_data  <= cipher;
        out_valid <= 1'b1;
        out_last  <= count_is_last;
        key_full  <= 1'b0;
        if (!count_is_last) count <= count + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chaos_pixel_diffuser.sv
// Randomized self-checking bench for chaos_pixel_diffuser against a real-arithmetic reference model.
module tb_chaos_pixel_diffuser;

  localparam int PIXEL_W = 8;
  localparam int SHIFT   = 24;
  localparam int NUM_PIX = 4;
  localparam logic [7:0] IV = 8'h5A;
`ifdef CIPHER_CHAIN_EN
  localparam bit CHAIN_ON = 1'b1;
`else
  localparam bit CHAIN_ON = 1'b0;
`endif

  logic        clk, reset_n, start;
  logic        chaos_valid, chaos_ready;
  logic [31:0] chaos_in;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_in;
  logic        out_valid, out_ready, out_last, busy, nan_seen;
  logic [7:0]  out_data;

  chaos_pixel_diffuser #(
    .PRECISION(32), .PIXEL_W(PIXEL_W), .SHIFT(SHIFT), .NUM_PIX(NUM_PIX), .IV(IV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .chaos_valid(chaos_valid), .chaos_ready(chaos_ready), .chaos_in(chaos_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_in(pix_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .nan_seen(nan_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] chaos_src[$];
  logic [7:0]  pix_src[$];
  logic [7:0]  dut_log[$];
  int          ready_mode = 1;
  bit          last_seen = 1'b0;

  // Reference model state: image progress and pending ciphertext, tracked at transaction level
  bit          m_busy, m_pending, m_last, m_nan, m_key_held;
  logic [7:0]  m_data, m_key, m_chain;
  int          m_pix;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // floor(|x| * 2^SHIFT) mod 2^PIXEL_W evaluated as real arithmetic
  function automatic logic [7:0] quant_model(input logic [31:0] x);
    real v, scale;
    if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) return 8'h00;
    v = $bitstoreal({1'b0, 11'(int'(x[30:23]) + 896), x[22:0], 29'b0});
    scale = 1.0;
    for (int i = 0; i < SHIFT; i++) scale = scale * 2.0;
    v = v * scale;
    v = v - 256.0 * $floor(v / 256.0);
    return 8'($rtoi(v));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pending = 0; m_last = 0; m_nan = 0; m_key_held = 0;
    m_data = 8'h00; m_key = 8'h00; m_chain = IV; m_pix = 0;
  endtask

  always @(negedge clk) begin
    bit exp_cr, exp_pr, out_acc, start_acc;
    logic [7:0] c;
    if (!reset_n) begin
      model_reset();
    end else begin
      exp_cr = m_busy && (m_pix < NUM_PIX) && !m_key_held;
      exp_pr = m_busy && (m_pix < NUM_PIX) && m_key_held && pix_valid && (!m_pending || out_ready);
      check_output("busy", busy, m_busy);
      check_output("out_valid", out_valid, m_pending);
      check_output("chaos_ready", chaos_ready, exp_cr);
      check_output("pix_ready", pix_ready, exp_pr);
      check_output("nan_seen", nan_seen, m_nan);
      if (m_pending) begin
        check_output("out_data", out_data, m_data);
        check_output("out_last", out_last, m_last);
      end
      if (out_valid && out_ready) begin
        dut_log.push_back(out_data);
        if (out_last) last_seen = 1'b1;
      end
      out_acc   = m_pending && out_ready;
      start_acc = start && !m_busy;
      if (exp_cr && chaos_valid) begin
        m_key = quant_model(chaos_in);
        m_key_held = 1;
        if (chaos_in[30:23] == 8'hFF) m_nan = 1;
      end
      if (exp_pr) begin
        c = pix_in ^ m_key ^ (CHAIN_ON ? m_chain : 8'h00);
        m_chain = c; m_key_held = 0; m_pix++;
        m_data = c; m_last = (m_pix == NUM_PIX); m_pending = 1;
      end else if (out_acc) begin
        m_pending = 0;
        if (m_last) m_busy = 0;
      end
      if (start_acc) begin
        m_busy = 1; m_pix = 0; m_chain = IV; m_nan = 0; m_key_held = 0;
      end
    end
  end

  // Stream drivers: valid stays up until the handshake, gaps and out_ready are randomized
  initial begin
    bit ch_hs, px_hs;
    chaos_valid = 0; pix_valid = 0; chaos_in = '0; pix_in = '0; out_ready = 0;
    forever begin
      @(negedge clk);
      ch_hs = chaos_valid && chaos_ready;
      px_hs = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      if (ch_hs && chaos_src.size() > 0) void'(chaos_src.pop_front());
      if (px_hs && pix_src.size() > 0) void'(pix_src.pop_front());
      chaos_valid = (chaos_src.size() > 0) && ((chaos_valid && !ch_hs) || ($urandom_range(0, 3) != 0));
      chaos_in    = (chaos_src.size() > 0) ? chaos_src[0] : $urandom();
      pix_valid   = (pix_src.size() > 0) && ((pix_valid && !px_hs) || ($urandom_range(0, 3) != 0));
      pix_in      = (pix_src.size() > 0) ? pix_src[0] : 8'($urandom());
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic [31:0] ch[NUM_PIX], input logic [7:0] px[NUM_PIX]);
    dut_log.delete();
    last_seen = 1'b0;
    for (int i = 0; i < NUM_PIX; i++) begin
      chaos_src.push_back(ch[i]);
      pix_src.push_back(px[i]);
    end
  endtask

  task automatic start_image();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_output("busy_after_start", busy, 1);
    check_output("nan_cleared", nan_seen, 0);
  endtask

  task automatic wait_image(input int budget);
    for (int i = 0; i < budget && !last_seen; i++) @(negedge clk);
    if (!last_seen) check_output("image_done_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
    check_output("idle_busy", busy, 0);
    check_output("idle_chaos_ready", chaos_ready, 0);
  endtask

  task automatic wait_out_valid(input int budget);
    for (int i = 0; i < budget && !out_valid; i++) @(negedge clk);
    if (!out_valid) check_output("out_valid_timeout", 0, 1);
  endtask

  task automatic check_log(input string tag, input logic [7:0] exp[NUM_PIX]);
    check_output({tag, "_count"}, dut_log.size(), NUM_PIX);
    for (int i = 0; i < NUM_PIX; i++)
      if (i < dut_log.size()) check_output($sformatf("%s[%0d]", tag, i), dut_log[i], exp[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_chaos_ready"}, chaos_ready, 0);
    check_output({tag, "_pix_ready"}, pix_ready, 0);
    check_output({tag, "_out_valid"}, out_valid, 0);
    check_output({tag, "_out_data"}, out_data, 0);
    check_output({tag, "_out_last"}, out_last, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_nan_seen"}, nan_seen, 0);
  endtask

  function automatic logic [31:0] rand_sample();
    case ($urandom_range(0, 5))
      0:       return $urandom();
      1:       return 32'h7F800000 | 32'($urandom_range(0, 1)) << 22;
      2:       return 32'($urandom_range(0, 1)) << 31;
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 134)), 23'($urandom())};
    endcase
  endfunction

  initial begin
    logic [31:0] ch1[NUM_PIX];
    logic [7:0]  px1[NUM_PIX];
    logic [7:0]  exp1[NUM_PIX];
    logic [31:0] chr[NUM_PIX];
    logic [7:0]  pxr[NUM_PIX];

    ch1 = '{32'h3F123456, 32'h3F800000, 32'hBF123456, 32'h7FC00000};
    px1 = '{8'h00, 8'hFF, 8'h10, 8'h33};
    if (CHAIN_ON) exp1 = '{8'h0C, 8'hF3, 8'hB5, 8'h86};
    else          exp1 = '{8'h56, 8'hFF, 8'h46, 8'h33};

    reset_n = 1'b0;
    start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset");
    @(negedge clk) reset_n = 1'b1;

    check_output("quant_3F123456", quant_model(32'h3F123456), 8'h56);
    check_output("quant_3F800000", quant_model(32'h3F800000), 8'h00);
    check_output("quant_BF123456", quant_model(32'hBF123456), 8'h56);
    check_output("quant_7FC00000", quant_model(32'h7FC00000), 8'h00);
    check_output("quant_3E800001", quant_model(32'h3E800001), 8'h00);
    check_output("quant_00000000", quant_model(32'h00000000), 8'h00);
    check_output("quant_3F7FFFFF", quant_model(32'h3F7FFFFF), 8'hFF);

    $display("[TB] directed image, then identical image to confirm chain restart");
    for (int rep = 0; rep < 2; rep++) begin
      apply_stimulus(ch1, px1);
      start_image();
      wait_image(400);
      check_log("img1", exp1);
      check_output("img1_nan_sticky", nan_seen, 1);
      check_output("img1_idle_out_valid", out_valid, 0);
    end

    $display("[TB] output backpressure");
    ready_mode = 0;
    apply_stimulus(ch1, px1);
    start_image();
    wait_out_valid(200);
    repeat (5) begin
      @(negedge clk);
      check_output("stall_out_data", out_data, exp1[0]);
      check_output("stall_pix_ready", pix_ready, 0);
      check_output("stall_out_valid", out_valid, 1);
    end
    ready_mode = 1;
    wait_image(400);
    check_log("stall", exp1);

    $display("[TB] reset mid-image");
    for (int i = 0; i < NUM_PIX; i++) begin chr[i] = rand_sample(); pxr[i] = 8'($urandom()); end
    apply_stimulus(chr, pxr);
    start_image();
    wait_out_valid(200);
    @(posedge clk);
    #2 reset_n = 1'b0;
    chaos_src.delete();
    pix_src.delete();
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(ch1, px1);
    start_image();
    wait_image(400);
    check_log("after_reset", exp1);

    $display("[TB] randomized images");
    for (int img = 0; img < 8; img++) begin
      ready_mode = (img == 5) ? 2 : 1;
      for (int i = 0; i < NUM_PIX; i++) begin chr[i] = rand_sample(); pxr[i] = 8'($urandom()); end
      apply_stimulus(chr, pxr);
      start_image();
      if (img == 3) begin
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_image(400);
      check_output("rand_count", dut_log.size(), NUM_PIX);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
